// File: rtl/icache_assoc.sv
// Set-associative instruction cache of 16-bit parcels with round-robin
// replacement, its own miss handshake, a fence.i invalidate sequencer and hit/miss counters.
module icache_assoc #(
  parameter int XLEN    = 32,
  parameter int SET_CNT = 64,
  parameter int WAY_CNT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             stall,
  input  logic             fet_icache_enable,
  input  logic [XLEN-1:0]  fet_pc,
  input  logic             icache_inv,
  input  logic             mem_inst_ready,
  input  logic [XLEN-1:0]  mem_inst,
  input  logic [XLEN-1:0]  mem_inst_addr,
  output logic             icache_ready,
  output logic [XLEN-1:0]  icache_inst,
  output logic             icache_req,
  output logic [XLEN-1:0]  icache_req_addr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // state | meaning
  // IDLE  | lookups served, misses launched
  // MISS  | request outstanding at icache_req_addr, waiting for matching fill
  // INVAL | clearing one set per cycle, lookups and requests suppressed
  typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1, INVAL = 2'd2} state_t;

  localparam int IDX_W = $clog2(SET_CNT);
  localparam int TAG_W = XLEN - IDX_W - 1;
  localparam int RR_W  = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  state_t             state_q;
  logic [WAY_CNT-1:0] valid_q [SET_CNT];
  logic [RR_W-1:0]    rr_q    [SET_CNT];
  logic [TAG_W-1:0]   tag_q   [WAY_CNT][SET_CNT];
  logic [15:0]        data_q  [WAY_CNT][SET_CNT];
  logic [IDX_W-1:0]   inv_idx;

  logic [XLEN-1:0]  pc1;
  logic [IDX_W-1:0] idx0, idx1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             h0, h1, rvc;
  logic [15:0]      p0, p1;

  assign pc1  = fet_pc + XLEN'(2);
  assign idx0 = fet_pc[IDX_W:1];
  assign tag0 = fet_pc[XLEN-1:IDX_W+1];
  assign idx1 = pc1[IDX_W:1];
  assign tag1 = pc1[XLEN-1:IDX_W+1];

  // The two parcels may hit in different ways.
  always_comb begin
    h0 = 1'b0;
    h1 = 1'b0;
    p0 = '0;
    p1 = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_q[idx0][w] && tag_q[w][idx0] == tag0) begin
        h0 = 1'b1;
        p0 = data_q[w][idx0];
      end
      if (valid_q[idx1][w] && tag_q[w][idx1] == tag1) begin
        h1 = 1'b1;
        p1 = data_q[w][idx1];
      end
    end
  end

  assign rvc          = (p0[1:0] != 2'b11);
  assign icache_ready = (state_q == IDLE) && fet_icache_enable && h0 && (rvc || h1);

  always_comb begin
    icache_inst = '0;
    if (icache_ready) begin
      icache_inst[15:0] = p0;
      if (!rvc) icache_inst[31:16] = p1;
    end
  end

  // Fill side: parcel numbers of the two halves of the response.
  logic [XLEN-2:0]  fp0, fp1;
  logic [IDX_W-1:0] fs0, fs1;
  logic [TAG_W-1:0] ft0, ft1;
  logic [RR_W-1:0]  vic0, vic1;
  logic             full0, full1, fill;

  function automatic logic [RR_W-1:0] pick_way(input logic [WAY_CNT-1:0] v,
                                               input logic [RR_W-1:0] rr);
    logic [RR_W-1:0] r;
    r = rr;
    for (int w = WAY_CNT - 1; w >= 0; w--)
      if (!v[w]) r = RR_W'(w);
    return r;
  endfunction

  assign fp0   = icache_req_addr[XLEN-1:1];
  assign fp1   = fp0 + (XLEN-1)'(1);
  assign fs0   = fp0[IDX_W-1:0];
  assign ft0   = fp0[XLEN-2:IDX_W];
  assign fs1   = fp1[IDX_W-1:0];
  assign ft1   = fp1[XLEN-2:IDX_W];
  assign vic0  = pick_way(valid_q[fs0], rr_q[fs0]);
  assign vic1  = pick_way(valid_q[fs1], rr_q[fs1]);
  assign full0 = &valid_q[fs0];
  assign full1 = &valid_q[fs1];
  assign fill  = (state_q == MISS) && mem_inst_ready && (mem_inst_addr == icache_req_addr)
                 && !icache_inv && !flush;

  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_q[vic0][fs0]  <= ft0;
      data_q[vic0][fs0] <= mem_inst[15:0];
      tag_q[vic1][fs1]  <= ft1;
      data_q[vic1][fs1] <= mem_inst[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      icache_req      <= 1'b0;
      icache_req_addr <= '0;
      inv_idx         <= '0;
      hit_cnt         <= '0;
      miss_cnt        <= '0;
      for (int s = 0; s < SET_CNT; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (rdy) begin
      if (icache_ready && !stall && !flush) hit_cnt <= hit_cnt + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (icache_inv) begin
            state_q <= INVAL;
            inv_idx <= '0;
          end else if (fet_icache_enable && !icache_ready && !stall && !flush) begin
            state_q         <= MISS;
            icache_req      <= 1'b1;
            icache_req_addr <= h0 ? pc1 : fet_pc;
            miss_cnt        <= miss_cnt + CNT_W'(1);
          end
        end
        MISS: begin
          if (icache_inv) begin
            state_q    <= INVAL;
            inv_idx    <= '0;
            icache_req <= 1'b0;
          end else if (flush) begin
            state_q    <= IDLE;
            icache_req <= 1'b0;
          end else if (fill) begin
            state_q             <= IDLE;
            icache_req          <= 1'b0;
            valid_q[fs0][vic0]  <= 1'b1;
            valid_q[fs1][vic1]  <= 1'b1;
            if (full0) rr_q[fs0] <= RR_W'((32'(rr_q[fs0]) + 1) % WAY_CNT);
            if (full1) rr_q[fs1] <= RR_W'((32'(rr_q[fs1]) + 1) % WAY_CNT);
          end
        end
        INVAL: begin
          valid_q[inv_idx] <= '0;
          inv_idx          <= inv_idx + IDX_W'(1);
          if (inv_idx == IDX_W'(SET_CNT - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
